// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the burst round-robin arbiter
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Index width for an N-way one-hot, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational round-robin picker, wrap-around double token chain
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] prio,
    output logic [N-1:0] gnt
);

    // The chain is unrolled twice so a token injected at prio can wrap past N-1 back to 0
    logic [2*N-1:0] tok;

    always_comb begin
        tok    = '0;
        gnt    = '0;
        tok[0] = prio[0];
        for (int i = 1; i < 2*N; i++) begin
            tok[i] = prio[i % N] | (tok[i-1] & ~req[(i-1) % N]);
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = req[i] & (tok[i] | tok[i+N]);
        end
    end

endmodule

// File: rtl/arb_burst_rr.sv
// rtl/arb_burst_rr.sv - burst-locking round-robin arbiter for one shared valid/ready channel
module arb_burst_rr
    import arb_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int MAX_BEATS = 16,
    localparam int SW        = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_valid,
    input  logic [N-1:0]  req_last,
    output logic [N-1:0]  req_ready,
    output logic [N-1:0]  gnt,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [SW-1:0] out_src,
    output logic          busy,
    output logic          overrun
);

    localparam int            CW       = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  prio_q, prio_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  pick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overrun_q, overrun_d;
    logic          beat;

    arb_rr_pick #(.N(N)) u_pick (
        .req  (req_valid),
        .prio (prio_q),
        .gnt  (pick)
    );

    // Channel control depends only on the registered owner; rst blocks any beat in the reset cycle
    assign out_valid = ~rst & (|(req_valid & gnt_q));
    assign out_last  = |(req_last & gnt_q);
    assign req_ready = gnt_q & {N{out_ready & ~rst}};
    assign beat      = out_valid & out_ready;

    assign gnt     = gnt_q;
    assign busy    = (state_q == ARB_LOCK);
    assign overrun = overrun_q;

    always_comb begin
        out_src = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                out_src = out_src | SW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        overrun_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    state_d = ARB_LOCK;
                    gnt_d   = pick;
                    cnt_d   = '0;
                end
            end
            ARB_LOCK: begin
                if (beat) begin
                    if (out_last || (cnt_q == LAST_CNT)) begin
                        state_d   = ARB_IDLE;
                        gnt_d     = '0;
                        cnt_d     = '0;
                        prio_d    = {gnt_q[N-2:0], gnt_q[N-1]};
                        overrun_d = ~out_last;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            prio_q    <= {{(N-1){1'b0}}, 1'b1};
            gnt_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_arb_burst_rr.sv
// tb/tb_arb_burst_rr.sv - directed self-checking bench for arb_burst_rr
module tb_arb_burst_rr;

    localparam int N  = 8;
    localparam int MB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic [N-1:0] gnt;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [2:0]   out_src;
    logic         busy;
    logic         overrun;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    logic [N-1:0] prev_gnt = '0;

    arb_burst_rr #(.N(N), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every new grant must match the next expected owner index
    always @(negedge clk) begin
        if (gnt != '0 && prev_gnt == '0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_grant", 32'(gnt), 32'h0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("sb_out_src", 32'(out_src), 32'(e));
                chk("sb_gnt", 32'(gnt), 32'(1 << e));
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        #100000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0; #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_req_ready", 32'(req_ready), 0);

        // 3-beat burst from 0 while 2 waits, then 2 after the bubble
        req_valid = 8'b0000_0101; out_ready = 1'b1; exp_q.push_back(0); #1;
        chk("idle_req_ready", 32'(req_ready), 0);
        cyc();
        chk("b1_gnt", 32'(gnt), 32'h01);
        chk("b1_busy", 32'(busy), 1);
        chk("b1_req_ready", 32'(req_ready), 32'h01);
        chk("b1_out_valid", 32'(out_valid), 1);
        cyc();
        chk("b2_gnt", 32'(gnt), 32'h01);
        cyc();
        req_last = 8'b0000_0001; #1;
        chk("b3_out_last", 32'(out_last), 1);
        cyc();
        req_valid = 8'b0000_0100; req_last = '0; exp_q.push_back(2); #1;
        chk("bubble_gnt", 32'(gnt), 0);
        chk("bubble_busy", 32'(busy), 0);
        chk("bubble_out_valid", 32'(out_valid), 0);
        cyc();
        chk("s1_gnt2", 32'(gnt), 32'h04);
        chk("s1_src2", 32'(out_src), 2);
        req_last = 8'b0000_0100;
        cyc();
        req_valid = '0; req_last = '0;

        // owner 3 goes quiet mid-burst while 5 keeps requesting
        req_valid = 8'b0010_1000; exp_q.push_back(3);
        cyc();
        chk("gap_gnt_start", 32'(gnt), 32'h08);
        cyc();
        req_valid = 8'b0010_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("gap_gnt", 32'(gnt), 32'h08);
            chk("gap_req_ready", 32'(req_ready), 32'h08);
            chk("gap_out_valid", 32'(out_valid), 0);
            cyc();
        end
        req_valid = 8'b0010_1000; req_last = 8'b0000_1000; #1;
        chk("gap_out_last", 32'(out_last), 1);
        cyc();
        req_valid = 8'b0010_0000; req_last = 8'b0010_0000; exp_q.push_back(5); #1;
        chk("gap_release", 32'(gnt), 0);
        cyc();
        chk("s2_gnt5", 32'(gnt), 32'h20);
        cyc();
        req_valid = '0; req_last = '0;

        // watchdog: requester 1 streams 20 beats without last
        req_valid = 8'b0000_0010; exp_q.push_back(1);
        cyc();
        for (int b = 1; b <= MB; b++) begin
            chk("wd_busy", 32'(busy), 1);
            chk("wd_no_overrun", 32'(overrun), 0);
            cyc();
        end
        chk("wd_released", 32'(gnt), 0);
        chk("wd_overrun", 32'(overrun), 1);
        exp_q.push_back(1);
        cyc();
        chk("wd_regrant", 32'(gnt), 32'h02);
        chk("wd_overrun_once", 32'(overrun), 0);
        cyc(); cyc(); cyc();
        req_last = 8'b0000_0010;
        cyc();
        chk("wd_tail_release", 32'(gnt), 0);
        chk("wd_tail_no_overrun", 32'(overrun), 0);
        req_valid = '0; req_last = '0;

        // all eight with single-beat bursts, starting from fresh priority
        rst = 1'b1;
        cyc();
        rst = 1'b0; req_valid = '1; req_last = '1;
        for (int k = 0; k <= N; k++) exp_q.push_back(k % N);
        for (int k = 0; k <= N; k++) begin
            cyc();
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
            cyc();
            chk("rr_idle", 32'(gnt), 0);
            if (k == N) begin
                req_valid = '0; req_last = '0;
            end
        end

        // sink stall, then reset mid-burst
        req_valid = 8'b0000_0010; exp_q.push_back(1);
        cyc();
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_gnt", 32'(gnt), 32'h02);
            chk("stall_cnt", 32'(dut.cnt_q), 1);
            cyc();
        end
        out_ready = 1'b1; rst = 1'b1; #1;
        chk("rst_cycle_req_ready", 32'(req_ready), 0);
        cyc();
        rst = 1'b0; req_valid = '0; #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_prio", 32'(dut.prio_q), 1);
        chk("midrst_busy", 32'(busy), 0);
        req_valid = '1; req_last = 8'b0000_0001; exp_q.push_back(0);
        cyc();
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        req_valid = '0;
        cyc();
        req_last = '0;
        cyc();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arb_burst_rr.md
# arb_burst_rr

Burst-locking round-robin arbiter that shares one downstream valid/ready channel among N requesters. A requester that wins arbitration owns the channel until it completes a burst (beat with `req_last`) or exceeds the MAX_BEATS watchdog. The block sits between the requester ports and a shared sink. It drives only control (grant, ready, source index). The data mux is external and steered by `out_src`.

## Interface
- N, 8, number of requesters (≥2)
- MAX_BEATS, 16, beat limit per burst before forced release (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  N  per-requester beat valid
- req_last  in  N  per-requester last-beat flag, meaningful with req_valid
- req_ready  out  N  per-requester beat accept; at most one bit set
- gnt  out  N  registered one-hot owner; all-zero when idle
- out_valid  out  1  shared channel valid
- out_last  out  1  shared channel last
- out_ready  in  1  shared channel ready from sink
- out_src  out  $clog2(N)  owner index, 0 when idle
- busy  out  1  high while in LOCK
- overrun  out  1  one-cycle pulse on watchdog release

## Operation
- State machine has two states.
  - IDLE: `gnt`=0, `out_valid`=0, `req_ready`=0.
  - LOCK: the owner is stored in `gnt`.
- IDLE→LOCK happens when any `req_valid` is set. The winner is chosen by the round-robin picker from `req_valid` and the one-hot priority vector `prio`. The winner is the first set request at or after the `prio` position, wrapping from N-1 to 0.
- In LOCK:
  - `out_valid` = `req_valid[owner]`.
  - `out_last` = `req_last[owner]`.
  - `req_ready[owner]` = `out_ready`; all other `req_ready` bits are 0.
  - A beat is `out_valid & out_ready`.
- The owner keeps the lock while its `req_valid` is low; gaps inside a burst are legal.
- Beat counter: width $clog2(MAX_BEATS). It clears on entry to LOCK and increments on every beat.
- Normal release: a beat with `out_last`=1 moves LOCK→IDLE.
- Forced release: a beat with count = MAX_BEATS-1 and `out_last`=0 moves LOCK→IDLE and pulses `overrun` on the next cycle. The source's remaining beats form a new burst that competes normally.
- On any release, `prio` ← owner rotated left by one, so owner+1 mod N becomes highest priority. `prio` does not change otherwise.
- Requests from non-owners are ignored during LOCK. They are not latched; `req_valid` must be held until accepted.

## Timing
- Reset values:
  - state=IDLE, `prio`=1 (requester 0 highest), count=0.
  - `gnt`=0, `busy`=0, `overrun`=0, `out_src`=0.
  - `out_valid`=0, `out_last`=0, `req_ready`=0.
- Reset takes precedence over all events, including mid-burst. No beat is accepted in the reset cycle.
- Arbitration latency is one cycle. A request sampled in IDLE at edge t gives `gnt`/`busy` at t+1, and the first beat is possible in cycle t+1.
- There is one mandatory IDLE bubble cycle after every release, so back-to-back bursts are spaced by ≥1 idle cycle.
- `req_ready` and `out_valid` are combinational from `gnt` plus `out_ready`/`req_valid`. There are no combinational paths from `req_valid` of non-owners.
- `overrun` is registered and high for exactly one cycle, coincident with the first IDLE cycle.
- A single-beat burst (`req_last`=1 on the first beat) releases after one LOCK cycle, provided `out_ready`=1.

## Structure
- Package `arb_pkg` holds:
  - the state enum (ARB_IDLE, ARB_LOCK);
  - the index-width helper for `out_src`.
- Sub-module `arb_rr_pick`, parameter N: purely combinational. It takes `req[N]` and one-hot `prio[N]` and returns one-hot `gnt[N]`, implemented as a wrap-around double token chain. It is reusable by other arbiters.
- The top level holds:
  - the FSM;
  - the `prio`, `gnt` and beat-count registers;
  - the one-hot-to-index encoder for `out_src`.

## Test plan
- Reset then `req_valid`=8'b0000_0101: `gnt`=8'b0000_0001 after 1 cycle. 3-beat burst with `out_ready`=1, then release. After the bubble, `gnt`=8'b0000_0100 and `out_src`=2.
- Owner 3 deasserts `req_valid` for 4 cycles mid-burst while requester 5 is valid: `gnt` stays 8'b0000_1000, `req_ready[5]`=0 throughout.
- MAX_BEATS=16, requester 1 sends 20 beats without `req_last`: release after beat 16, `overrun` pulses once, requester 1 re-granted after the bubble when alone.
- All 8 requesting continuously with 1-beat bursts: grant order 0,1,2…7,0, each grant separated by exactly one idle cycle.
- `out_ready`=0 for 5 cycles during a burst: `req_ready`=0, count unchanged, lock held. Assert `rst` mid-burst: next cycle `gnt`=0 and `prio`=1.
